// File: rtl/pipe_skid_stage.sv
// Pipeline-stage register with ready/valid on both sides, synchronous flush and an
// optional skid entry that lets in_ready come straight from a flop.
module pipe_skid_stage #(
  parameter int PAYLOAD_W     = 160,
  parameter int SKID          = 1,
  parameter int CLEAR_PAYLOAD = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [1:0]           occupancy
);

  logic                 m_valid;
  logic                 s_valid;
  logic                 ready_q;
  logic [PAYLOAD_W-1:0] m_data;
  logic [PAYLOAD_W-1:0] s_data;

  logic accept;
  logic consume;
  logic clear;
  logic m_valid_n;
  logic s_valid_n;
  logic m_load;
  logic m_from_s;
  logic s_load;

  assign accept   = in_valid & in_ready;
  assign consume  = m_valid & out_ready;
  assign clear    = reset | flush;
  assign in_ready = (SKID != 0) ? ready_q : (!m_valid | out_ready);

  assign out_valid = m_valid;
  assign out_data  = m_data;

  // Next-state of the two entries; the skid entry only fills when main is stalled.
  always_comb begin
    m_valid_n = m_valid;
    s_valid_n = s_valid;
    m_load    = 1'b0;
    m_from_s  = 1'b0;
    s_load    = 1'b0;
    if (SKID != 0) begin
      if (!m_valid) begin
        if (accept) begin
          m_valid_n = 1'b1;
          m_load    = 1'b1;
        end
      end else if (s_valid) begin
        if (consume) begin
          s_valid_n = 1'b0;
          m_from_s  = 1'b1;
        end
      end else if (consume) begin
        if (accept) begin
          m_load = 1'b1;
        end else begin
          m_valid_n = 1'b0;
        end
      end else if (accept) begin
        s_valid_n = 1'b1;
        s_load    = 1'b1;
      end
    end else begin
      s_valid_n = 1'b0;
      if (accept) begin
        m_valid_n = 1'b1;
        m_load    = 1'b1;
      end else if (consume) begin
        m_valid_n = 1'b0;
      end
    end
  end

  // Reset and flush empty the stage identically; an accept in that cycle is dropped.
  always_ff @(posedge clk) begin
    if (clear) begin
      m_valid   <= 1'b0;
      s_valid   <= 1'b0;
      ready_q   <= 1'b1;
      occupancy <= 2'd0;
    end else begin
      m_valid   <= m_valid_n;
      s_valid   <= s_valid_n;
      ready_q   <= !s_valid_n;
      occupancy <= {1'b0, m_valid_n} + {1'b0, s_valid_n};
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      if (CLEAR_PAYLOAD != 0) begin
        m_data <= '0;
        s_data <= '0;
      end
    end else begin
      if (m_load) begin
        m_data <= in_data;
      end else if (m_from_s) begin
        m_data <= s_data;
      end
      if (s_load) begin
        s_data <= in_data;
      end
    end
  end

  a_skid_implies_main: assert property (@(posedge clk) disable iff (reset)
    s_valid |-> m_valid);

  a_occupancy_matches: assert property (@(posedge clk) disable iff (reset)
    occupancy == ({1'b0, m_valid} + {1'b0, s_valid}));

  a_stall_stable: assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready && !flush) |=> $stable(out_data));

  generate
    if (SKID == 0) begin : g_single
      a_single_entry: assert property (@(posedge clk) disable iff (reset)
        occupancy <= 2'd1);
    end else begin : g_skid
      a_ready_registered: assert property (@(posedge clk) disable iff (reset)
        in_ready == !s_valid);
    end
  endgenerate

endmodule
